// File: rtl/am_audio_decim_dcblock.sv
// AM audio back-end: boxcar-average and decimate the demodulator magnitude,
// then strip the carrier level with a leaky DC tracker and emit signed audio.
module am_audio_decim_dcblock #(
   parameter int unsigned LOG2_DECIM = 6,
   parameter int unsigned DC_SHIFT   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] d_in,
   input  logic        in_valid,
   output logic [11:0] audio_out,
   output logic [11:0] dc_out,
   output logic        out_valid
);

   localparam int unsigned CW = LOG2_DECIM;
   localparam int unsigned AW = 12 + LOG2_DECIM;
   localparam int unsigned DW = 13 + DC_SHIFT;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic {S_WARM, S_RUN} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         acc_q, acc_d;
   logic [11:0]           avg_q, avg_d;
   logic                  dump_q, dump_d;
   logic                  stage_q, stage_d;
   logic signed [13:0]    diff_q, diff_d;
   logic signed [DW-1:0]  dc_acc_q, dc_acc_d;
   logic [11:0]           audio_q, audio_d;
   logic [11:0]           dc_out_q, dc_out_d;
   logic                  out_valid_q, out_valid_d;

   logic [AW-1:0]         sum;
   logic signed [12:0]    dc_int;
   logic signed [12:0]    dc_new;
   logic signed [13:0]    avg_s;
   logic signed [13:0]    dci_s;
   logic signed [13:0]    diff;
   logic signed [DW-1:0]  dc_acc_nxt;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      avg_d       = avg_q;
      dump_d      = 1'b0;
      stage_d     = 1'b0;
      diff_d      = diff_q;
      dc_acc_d    = dc_acc_q;
      audio_d     = audio_q;
      dc_out_d    = dc_out_q;
      out_valid_d = 1'b0;

      // Block accumulator; the wrapping sample is folded into the average.
      sum = acc_q + AW'(d_in);
      if (in_valid) begin
         if (cnt_q == CNT_MAX) begin
            avg_d  = 12'(sum >> LOG2_DECIM);
            acc_d  = '0;
            cnt_d  = '0;
            dump_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
         end
      end

      // Integer part of the DC estimate is the top 13 bits of dc_acc.
      dc_int = dc_acc_q[DW-1:DC_SHIFT];
      avg_s  = {2'b00, avg_q};
      dci_s  = {dc_int[12], dc_int};
      diff   = avg_s - dci_s;
      if (dump_q) begin
         diff_d  = diff;
         stage_d = 1'b1;
      end

      dc_acc_nxt = dc_acc_q + DW'(diff_q);
      dc_new     = dc_acc_nxt[DW-1:DC_SHIFT];
      if (stage_q) begin
         out_valid_d = 1'b1;
         case (state_q)
            S_WARM: begin
               dc_acc_d = DW'(avg_q) << DC_SHIFT;
               audio_d  = '0;
               dc_out_d = avg_q;
               state_d  = S_RUN;
            end
            default: begin
               if (diff_q > 14'sd2047)
                  audio_d = 12'h7FF;
               else if (diff_q < -14'sd2048)
                  audio_d = 12'h800;
               else
                  audio_d = diff_q[11:0];
               dc_acc_d = dc_acc_nxt;
               dc_out_d = dc_new[12] ? 12'd0 : dc_new[11:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WARM;
         cnt_q       <= '0;
         acc_q       <= '0;
         avg_q       <= '0;
         dump_q      <= 1'b0;
         stage_q     <= 1'b0;
         diff_q      <= '0;
         dc_acc_q    <= '0;
         audio_q     <= '0;
         dc_out_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         avg_q       <= avg_d;
         dump_q      <= dump_d;
         stage_q     <= stage_d;
         diff_q      <= diff_d;
         dc_acc_q    <= dc_acc_d;
         audio_q     <= audio_d;
         dc_out_q    <= dc_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign audio_out = audio_q;
   assign dc_out    = dc_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_am_audio_decim_dcblock.sv
// Directed bench for am_audio_decim_dcblock at LOG2_DECIM=2, DC_SHIFT=2.
module tb_am_audio_decim_dcblock;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] d_in = '0;
   logic        in_valid = 1'b0;
   logic [11:0] audio_out;
   logic [11:0] dc_out;
   logic        out_valid;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int wide   = 0;
   logic ov_prev = 1'b0;
   int aq[$];
   int dq[$];
   int cq[$];
   int last_acc;

   am_audio_decim_dcblock #(.LOG2_DECIM(2), .DC_SHIFT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d_in      (d_in),
      .in_valid  (in_valid),
      .audio_out (audio_out),
      .dc_out    (dc_out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every strobe with its cycle stamp; flag strobes wider than one cycle.
   always @(negedge clk) begin
      if (out_valid) begin
         aq.push_back(int'($signed(audio_out)));
         dq.push_back(int'(dc_out));
         cq.push_back(cyc);
         if (ov_prev) wide <= wide + 1;
      end
      ov_prev <= out_valid;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int qa(input int i);
      return (i < aq.size()) ? aq[i] : -99999;
   endfunction
   function automatic int qd(input int i);
      return (i < dq.size()) ? dq[i] : -99999;
   endfunction
   function automatic int qc(input int i);
      return (i < cq.size()) ? cq[i] : -99999;
   endfunction

   task automatic clear_q();
      aq.delete();
      dq.delete();
      cq.delete();
   endtask

   task automatic drive(input int d, input logic v);
      d_in     = 12'(d);
      in_valid = v;
      @(posedge clk);
      #1;
      if (v) last_acc = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1'b0);
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
   endtask

   initial begin
      int acc_cyc;
      int sum, avg, dca, dint, diff, ea, ed, exp_sum, obs_sum;

      rst_n = 1'b0;
      #1;
      chk("reset_audio", int'(audio_out), 0);
      chk("reset_dc", int'(dc_out), 0);
      chk("reset_valid", int'(out_valid), 0);
      apply_reset();

      // Test 1: constant 1000 -> warm-up then zero audio, 4-cycle strobe spacing
      drive(1000, 1'b1); drive(1000, 1'b1); drive(1000, 1'b1); drive(1000, 1'b1);
      acc_cyc = last_acc;
      for (int i = 0; i < 12; i++) drive(1000, 1'b1);
      idle(3);
      chk("t1_count", aq.size(), 4);
      chk("t1_latency", qc(0) - acc_cyc, 2);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_audio%0d", i), qa(i), 0);
         chk($sformatf("t1_dc%0d", i), qd(i), 1000);
      end
      for (int i = 1; i < 4; i++) chk($sformatf("t1_space%0d", i), qc(i) - qc(i-1), 4);

      // Test 2: step to 1400, leaky tracker response
      clear_q();
      for (int i = 0; i < 16; i++) drive(1400, 1'b1);
      idle(3);
      chk("t2_count", aq.size(), 4);
      chk("t2_audio0", qa(0), 400);  chk("t2_dc0", qd(0), 1100);
      chk("t2_audio1", qa(1), 300);  chk("t2_dc1", qd(1), 1175);
      chk("t2_audio2", qa(2), 225);  chk("t2_dc2", qd(2), 1231);
      chk("t2_audio3", qa(3), 169);  chk("t2_dc3", qd(3), 1273);

      // Test 3: truncating average, contiguous and with in_valid gaps
      apply_reset();
      drive(1, 1'b1); drive(2, 1'b1); drive(3, 1'b1); drive(4, 1'b1);
      acc_cyc = last_acc;
      idle(3);
      chk("t3a_count", aq.size(), 1);
      chk("t3a_dc", qd(0), 2);
      chk("t3a_audio", qa(0), 0);
      chk("t3a_latency", qc(0) - acc_cyc, 2);
      apply_reset();
      drive(1, 1'b1); drive(999, 1'b0); drive(2, 1'b1); drive(999, 1'b0);
      drive(3, 1'b1); drive(999, 1'b0); drive(4, 1'b1);
      acc_cyc = last_acc;
      drive(999, 1'b0); idle(3);
      chk("t3b_count", aq.size(), 1);
      chk("t3b_dc", qd(0), 2);
      chk("t3b_audio", qa(0), 0);
      chk("t3b_latency", qc(0) - acc_cyc, 2);

      // Test 4: full-scale step from a zero carrier saturates audio
      apply_reset();
      for (int i = 0; i < 4; i++) drive(0, 1'b1);
      for (int i = 0; i < 4; i++) drive(4095, 1'b1);
      idle(3);
      chk("t4_count", aq.size(), 2);
      chk("t4_warm_dc", qd(0), 0);
      chk("t4_audio", qa(1), 2047);
      chk("t4_dc", qd(1), 1023);
      chk("t4_hold_audio", int'($signed(audio_out)), 2047);

      // Test 5: reset mid-block discards the partial sum and restarts warm-up
      clear_q();
      drive(1000, 1'b1); drive(1000, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_audio", int'(audio_out), 0);
      chk("t5_async_dc", int'(dc_out), 0);
      chk("t5_async_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
      drive(500, 1'b1); drive(500, 1'b1); drive(500, 1'b1);
      idle(3);
      chk("t5_no_early", aq.size(), 0);
      drive(500, 1'b1);
      acc_cyc = last_acc;
      idle(3);
      chk("t5_count", aq.size(), 1);
      chk("t5_latency", qc(0) - acc_cyc, 2);
      chk("t5_audio", qa(0), 0);
      chk("t5_dc", qd(0), 500);

      // Test 6: 64 back-to-back samples, compare against an arithmetic model
      apply_reset();
      wide = 0;
      exp_sum = 0;
      sum = 0;
      dca = 0;
      for (int i = 0; i < 64; i++) begin
         int s;
         s = (i * 613 + 100) % 4096;
         drive(s, 1'b1);
         sum += s;
         if (i % 4 == 3) begin
            avg = sum / 4;
            sum = 0;
            if (i == 3) begin
               dca = avg * 4;
               ea  = 0;
               ed  = avg;
            end else begin
               dint = dca >>> 2;
               diff = avg - dint;
               ea   = (diff > 2047) ? 2047 : ((diff < -2048) ? -2048 : diff);
               dca  = dca + diff;
               dint = dca >>> 2;
               ed   = (dint < 0) ? 0 : ((dint > 4095) ? 4095 : dint);
            end
            exp_sum += ea * 3 + ed;
         end
      end
      idle(3);
      chk("t6_count", aq.size(), 16);
      chk("t6_wide", wide, 0);
      obs_sum = 0;
      for (int i = 0; i < aq.size(); i++) obs_sum += aq[i] * 3 + dq[i];
      chk("t6_checksum", obs_sum, exp_sum);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
